// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter in front of a single-port synchronous memory.
// An instruction-fetch port (read only) and a data port (read/write) compete
// for one memory access per cycle. Grants are combinational in the request
// cycle; ties are broken round-robin against the most recent grant. Read data
// (or a write acknowledge on the data port) is returned one cycle after the
// grant, steered by a small response FSM.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and word address
//   if_gnt                   fetch accepted this cycle
//   if_rvalid/if_rdata       fetch response (one cycle after grant)
//   d_req/d_we/d_addr/d_wdata  data-port request
//   d_gnt                    data request accepted this cycle
//   d_rvalid/d_rdata         data response / write acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata                memory read data, one cycle after a read command
//   conflict_cnt             saturating count of cycles with both requests
module mem_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          last_d_r;       // 1: data port was granted most recently
    logic          d_we_r;         // write flag of the outstanding data access
    logic [15:0]   conflict_cnt_r;
    logic          both_s;
    logic          grant_if_s;
    logic          grant_d_s;

    // Arbitration: single requester wins; on conflict, the one not granted last.
    // Reset is folded in so that grants drop the moment rst goes low.
    always_comb begin
        both_s     = 1'b0;
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (rst) begin
            both_s     = if_req & d_req;
            grant_if_s = if_req & (~d_req | last_d_r);
            grant_d_s  = d_req & (~if_req | ~last_d_r);
        end else begin
            both_s     = 1'b0;
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // Memory command mux driven from the granted requester.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (grant_if_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = {DW{1'b0}};
        end else if (grant_d_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    // Response FSM next state (any state may go anywhere) and response outputs.
    always_comb begin
        state_next_s = IDLE;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        if_rdata     = {DW{1'b0}};
        d_rdata      = {DW{1'b0}};
        if (grant_if_s) begin
            state_next_s = RESP_IF;
        end else if (grant_d_s) begin
            state_next_s = RESP_D;
        end else begin
            state_next_s = IDLE;
        end
        case (state_r)
            RESP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RESP_D: begin
                d_rvalid = 1'b1;
                // Writes are acknowledged with zero data.
                if (d_we_r) begin
                    d_rdata = {DW{1'b0}};
                end else begin
                    d_rdata = mem_rdata;
                end
            end
            default: begin
                if_rvalid = 1'b0;
                d_rvalid  = 1'b0;
            end
        endcase
    end

    // Response FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Last-grant memory and captured write flag, updated only on a grant.
    // Reset to "data" so the first conflict after reset goes to fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_r <= 1'b1;
            d_we_r   <= 1'b0;
        end else if (grant_if_s) begin
            last_d_r <= 1'b0;
        end else if (grant_d_s) begin
            last_d_r <= 1'b1;
            d_we_r   <= d_we;
        end else begin
            last_d_r <= last_d_r;
        end
    end

    // Saturating conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_r <= 16'd0;
        end else if (both_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign if_gnt       = grant_if_s;
    assign d_gnt        = grant_d_s;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
    endtask

    // Step to the next falling edge (inputs may then be changed).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // V1: reset dominates live requests.
    task automatic test_reset();
        step();
        rst    = 1'b0;
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
        checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
        step();
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
        checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt_hold got=%0d exp=0", conflict_cnt); end
        idle_inputs();
        rst = 1'b1;
    endtask

    // V2: single fetch read.
    task automatic test_fetch();
        step();
        if_req  = 1'b1;
        if_addr = 6'd5;
        #1;
        checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got=%b%b exp=10", if_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL fetch_cmd got en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        checks++; if (mem_addr !== 6'd5) begin failures++; $display("FAIL fetch_addr got=%0d exp=5", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL fetch_wdata got=%h exp=0", mem_wdata); end
        step();
        idle_inputs();
        mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL fetch_rvalid got=%b exp=1", if_rvalid); end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin failures++; $display("FAIL fetch_d_quiet got v=%b d=%h exp v=0 d=0", d_rvalid, d_rdata); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL fetch_idle_en got=%b exp=0", mem_en); end
        step();
        mem_rdata = 32'h0BADF00D;
        #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin failures++; $display("FAIL fetch_after got v=%b d=%h exp v=0 d=0", if_rvalid, if_rdata); end
        idle_inputs();
    endtask

    // V3: round-robin over four conflict cycles right after reset.
    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if_req    = 1'b1;
            if_addr   = 6'd10;
            d_req     = 1'b1;
            d_we      = 1'b0;
            d_addr    = 6'd20;
            mem_rdata = 32'h1000_0000 + k;
            #1;
            checks++; if (if_gnt !== ((k % 2) == 0) || d_gnt !== ((k % 2) == 1)) begin failures++; $display("FAIL rr_gnt k=%0d got=%b%b", k, if_gnt, d_gnt); end
            checks++; if (mem_addr !== (((k % 2) == 0) ? 6'd10 : 6'd20)) begin failures++; $display("FAIL rr_addr k=%0d got=%0d", k, mem_addr); end
            if (k > 0) begin
                checks++; if (if_rvalid !== ((k % 2) == 1) || d_rvalid !== ((k % 2) == 0)) begin failures++; $display("FAIL rr_rvalid k=%0d got=%b%b", k, if_rvalid, d_rvalid); end
            end
        end
        step();
        idle_inputs();
        mem_rdata = 32'h5555AAAA;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5555AAAA) begin failures++; $display("FAIL rr_last_resp got v=%b d=%h exp v=1 d=5555aaaa", d_rvalid, d_rdata); end
        checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL rr_cnt got=%0d exp=4", conflict_cnt); end
    endtask

    // V4: data write and its acknowledge.
    task automatic test_write();
        step();
        idle_inputs();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 6'd3;
        d_wdata = 32'h12345678;
        #1;
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=01", if_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_cmd got en=%b we=%b exp 1 1", mem_en, mem_we); end
        checks++; if (mem_addr !== 6'd3 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_addr_data got a=%0d d=%h exp a=3 d=12345678", mem_addr, mem_wdata); end
        step();
        idle_inputs();
        mem_rdata = 32'hFFFF0000;
        #1;
        checks++; if (d_rvalid !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", d_rvalid); end
        checks++; if (d_rdata !== 32'd0) begin failures++; $display("FAIL wr_ack_data got=%h exp=0", d_rdata); end
    endtask

    // Back-to-back accesses: a grant in the same cycle as the previous response.
    task automatic test_back_to_back();
        step();
        idle_inputs();
        if_req  = 1'b1;
        if_addr = 6'd7;
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL b2b_if_gnt got=%b exp=1", if_gnt); end
        step();
        idle_inputs();
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 6'd9;
        mem_rdata = 32'hCAFE0007;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_addr !== 6'd9 || mem_we !== 1'b0) begin failures++; $display("FAIL b2b_d_gnt got g=%b a=%0d we=%b exp g=1 a=9 we=0", d_gnt, mem_addr, mem_we); end
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE0007) begin failures++; $display("FAIL b2b_if_resp got v=%b d=%h exp v=1 d=cafe0007", if_rvalid, if_rdata); end
        step();
        idle_inputs();
        mem_rdata = 32'hCAFE0009;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0009 || if_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_d_resp got v=%b d=%h ifv=%b exp v=1 d=cafe0009 ifv=0", d_rvalid, d_rdata, if_rvalid); end
    endtask

    // V5: counter saturation with arbitration still alternating.
    task automatic test_saturate();
        int alt_err;
        alt_err = 0;
        do_reset();
        if_req = 1'b1;
        d_req  = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            #1;
            if (if_gnt !== ((i % 2) == 0) || d_gnt !== ((i % 2) == 1)) alt_err++;
            step();
        end
        #1;
        checks++; if (alt_err != 0) begin failures++; $display("FAIL sat_alternate got=%0d bad cycles exp=0", alt_err); end
        checks++; if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%h exp=ffff", conflict_cnt); end
        // 65540 grants so far (even count): this cycle goes to fetch.
        checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL sat_gnt got=%b%b exp=10", if_gnt, d_gnt); end
        step();
        #1;
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got g=%b%b c=%h exp g=01 c=ffff", if_gnt, d_gnt, conflict_cnt); end
        idle_inputs();
    endtask

    // V6: reset during a pending fetch response.
    task automatic test_reset_mid();
        do_reset();
        step();
        if_req  = 1'b1;
        if_addr = 6'd12;
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", if_gnt); end
        step();
        idle_inputs();
        mem_rdata = 32'h77777777;
        rst = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin failures++; $display("FAIL mid_drop got v=%b d=%h exp v=0 d=0", if_rvalid, if_rdata); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b%b exp=00", if_rvalid, d_rvalid); end
        step();
        if_req = 1'b1;
        d_req  = 1'b1;
        #1;
        checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL mid_stale2 got=%b exp=0", if_rvalid); end
        checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++; $display("FAIL mid_first_conflict got=%b%b exp=10", if_gnt, d_gnt); end
        step();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_round_robin();
        test_write();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
